// File: rtl/layer_mem_arbiter_if.sv
// Requester-side handshake bundle for the layer-memory arbiter.
// The requester drives the access fields; the arbiter returns grant and read data.
interface layer_mem_arbiter_if #(
   parameter int AW = 12,
   parameter int DW = 20
);
   logic          req;
   logic          we;
   logic [2:0]    sel;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          gnt;
   logic          rvalid;
   logic [DW-1:0] rdata;

   modport master (
      output req, we, sel, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, sel, addr, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/layer_mem_arbiter.sv
// Round-robin arbiter sharing the single layer-memory port between the
// convolution engine (r0) and the pooling engine (r1). Grants are
// combinational, memory commands are registered, and reads return on a
// fixed two-cycle latency to the requester that issued them.
module layer_mem_arbiter #(
   parameter int MAX_BURST = 4,
   parameter int AW        = 12,
   parameter int DW        = 20
) (
   input  logic                 clk,
   input  logic                 reset,
   layer_mem_arbiter_if.slave   r0,
   layer_mem_arbiter_if.slave   r1,
   output logic                 cwr,
   output logic                 crd,
   output logic [2:0]           csel,
   output logic [AW-1:0]        caddr_wr,
   output logic [AW-1:0]        caddr_rd,
   output logic [DW-1:0]        cdata_wr,
   input  logic [DW-1:0]        cdata_rd,
   output logic                 busy,
   output logic                 err_sel
);

   localparam logic [3:0] MAXB = 4'(MAX_BURST);

   // Arbitration state
   logic          owner_q, owner_d;
   logic [3:0]    cnt_q, cnt_d;
   // Registered memory command
   logic          cwr_q, cwr_d;
   logic          crd_q, crd_d;
   logic [2:0]    csel_q, csel_d;
   logic [AW-1:0] caddr_wr_q, caddr_wr_d;
   logic [AW-1:0] caddr_rd_q, caddr_rd_d;
   logic [DW-1:0] cdata_wr_q, cdata_wr_d;
   logic          err_q, err_d;
   // Read-return pipeline: stage 1 tracks the read issued last cycle
   logic          p1_vld_q, p1_vld_d;
   logic          p1_id_q, p1_id_d;
   logic          p1_rsv_q, p1_rsv_d;
   logic          r0_rvalid_q, r0_rvalid_d;
   logic          r1_rvalid_q, r1_rvalid_d;
   logic [DW-1:0] r0_rdata_q, r0_rdata_d;
   logic [DW-1:0] r1_rdata_q, r1_rdata_d;

   // Grant and muxed request fields
   logic          gnt0_s, gnt1_s, any_gnt_s, gid_s;
   logic          we_s, sel_ok_s;
   logic [2:0]    sel_s;
   logic [AW-1:0] addr_s;
   logic [DW-1:0] wdata_s;

   // Grant decision: owner keeps the port until its burst budget runs out while contended
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if (r0.req && r1.req) begin
         if (cnt_q < MAXB) begin
            gnt0_s = ~owner_q;
            gnt1_s = owner_q;
         end else begin
            gnt0_s = owner_q;
            gnt1_s = ~owner_q;
         end
      end else begin
         gnt0_s = r0.req;
         gnt1_s = r1.req;
      end
   end

   assign any_gnt_s = gnt0_s | gnt1_s;
   assign gid_s     = gnt1_s;
   assign we_s      = gnt1_s ? r1.we    : r0.we;
   assign sel_s     = gnt1_s ? r1.sel   : r0.sel;
   assign addr_s    = gnt1_s ? r1.addr  : r0.addr;
   assign wdata_s   = gnt1_s ? r1.wdata : r0.wdata;
   assign sel_ok_s  = (sel_s == 3'd1) || (sel_s == 3'd3);

   // Next-state: arbitration counters, memory command and read-return pipeline
   always_comb begin
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      cwr_d       = 1'b0;
      crd_d       = 1'b0;
      csel_d      = csel_q;
      caddr_wr_d  = caddr_wr_q;
      caddr_rd_d  = caddr_rd_q;
      cdata_wr_d  = cdata_wr_q;
      err_d       = 1'b0;
      p1_vld_d    = 1'b0;
      p1_id_d     = p1_id_q;
      p1_rsv_d    = p1_rsv_q;
      if (any_gnt_s) begin
         if (gid_s == owner_q) begin
            cnt_d = (cnt_q == 4'd15) ? 4'd15 : cnt_q + 4'd1;
         end else begin
            owner_d = gid_s;
            cnt_d   = 4'd1;
         end
         if (sel_ok_s) begin
            csel_d = sel_s;
            if (we_s) begin
               cwr_d      = 1'b1;
               caddr_wr_d = addr_s;
               cdata_wr_d = wdata_s;
            end else begin
               crd_d      = 1'b1;
               caddr_rd_d = addr_s;
            end
         end else begin
            // Reserved target: access is consumed but never reaches memory
            err_d = 1'b1;
         end
         p1_vld_d = ~we_s;
         p1_id_d  = gid_s;
         p1_rsv_d = ~sel_ok_s;
      end else begin
         cnt_d = 4'd0;
      end

      r0_rvalid_d = p1_vld_q & ~p1_id_q;
      r1_rvalid_d = p1_vld_q & p1_id_q;
      if (r0_rvalid_d) begin
         r0_rdata_d = p1_rsv_q ? '0 : cdata_rd;
      end else begin
         r0_rdata_d = r0_rdata_q;
      end
      if (r1_rvalid_d) begin
         r1_rdata_d = p1_rsv_q ? '0 : cdata_rd;
      end else begin
         r1_rdata_d = r1_rdata_q;
      end
   end

   // State registers; reset drops any read still in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner_q     <= 1'b0;
         cnt_q       <= 4'd0;
         cwr_q       <= 1'b0;
         crd_q       <= 1'b0;
         csel_q      <= 3'd0;
         caddr_wr_q  <= '0;
         caddr_rd_q  <= '0;
         cdata_wr_q  <= '0;
         err_q       <= 1'b0;
         p1_vld_q    <= 1'b0;
         p1_id_q     <= 1'b0;
         p1_rsv_q    <= 1'b0;
         r0_rvalid_q <= 1'b0;
         r1_rvalid_q <= 1'b0;
         r0_rdata_q  <= '0;
         r1_rdata_q  <= '0;
      end else begin
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         cwr_q       <= cwr_d;
         crd_q       <= crd_d;
         csel_q      <= csel_d;
         caddr_wr_q  <= caddr_wr_d;
         caddr_rd_q  <= caddr_rd_d;
         cdata_wr_q  <= cdata_wr_d;
         err_q       <= err_d;
         p1_vld_q    <= p1_vld_d;
         p1_id_q     <= p1_id_d;
         p1_rsv_q    <= p1_rsv_d;
         r0_rvalid_q <= r0_rvalid_d;
         r1_rvalid_q <= r1_rvalid_d;
         r0_rdata_q  <= r0_rdata_d;
         r1_rdata_q  <= r1_rdata_d;
      end
   end

   assign r0.gnt    = gnt0_s;
   assign r1.gnt    = gnt1_s;
   assign r0.rvalid = r0_rvalid_q;
   assign r1.rvalid = r1_rvalid_q;
   assign r0.rdata  = r0_rdata_q;
   assign r1.rdata  = r1_rdata_q;
   assign cwr       = cwr_q;
   assign crd       = crd_q;
   assign csel      = csel_q;
   assign caddr_wr  = caddr_wr_q;
   assign caddr_rd  = caddr_rd_q;
   assign cdata_wr  = cdata_wr_q;
   assign err_sel   = err_q;
   assign busy      = r0.req | r1.req | p1_vld_q | r0_rvalid_q | r1_rvalid_q;

endmodule

// File: tb/tb_layer_mem_arbiter.sv
// Directed bench for layer_mem_arbiter: reset, write/read command issue,
// read latency, burst fairness, reserved selects and reset during a read.
module tb_layer_mem_arbiter;
   localparam int AW = 12;
   localparam int DW = 20;

   logic          clk;
   logic          reset;
   logic          cwr, crd, busy, err_sel;
   logic [2:0]    csel;
   logic [AW-1:0] caddr_wr, caddr_rd;
   logic [DW-1:0] cdata_wr, cdata_rd;
   logic [DW-1:0] rd_val;

   int n_tests;
   int n_fail;

   layer_mem_arbiter_if #(.AW(AW), .DW(DW)) r0_if ();
   layer_mem_arbiter_if #(.AW(AW), .DW(DW)) r1_if ();

   layer_mem_arbiter #(.MAX_BURST(4), .AW(AW), .DW(DW)) dut (
      .clk      (clk),
      .reset    (reset),
      .r0       (r0_if.slave),
      .r1       (r1_if.slave),
      .cwr      (cwr),
      .crd      (crd),
      .csel     (csel),
      .caddr_wr (caddr_wr),
      .caddr_rd (caddr_rd),
      .cdata_wr (cdata_wr),
      .cdata_rd (cdata_rd),
      .busy     (busy),
      .err_sel  (err_sel)
   );

   // Memory model: read data presented continuously from rd_val
   assign cdata_rd = rd_val;

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic req, input logic we, input logic [2:0] sel,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
      r0_if.req = req; r0_if.we = we; r0_if.sel = sel; r0_if.addr = addr; r0_if.wdata = wd;
   endtask

   task automatic drive1(input logic req, input logic we, input logic [2:0] sel,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
      r1_if.req = req; r1_if.we = we; r1_if.sel = sel; r1_if.addr = addr; r1_if.wdata = wd;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, ".cwr"},      32'(cwr),          32'd0);
      check({tag, ".crd"},      32'(crd),          32'd0);
      check({tag, ".csel"},     32'(csel),         32'd0);
      check({tag, ".caddr_wr"}, 32'(caddr_wr),     32'd0);
      check({tag, ".cdata_wr"}, 32'(cdata_wr),     32'd0);
      check({tag, ".r0_rvalid"},32'(r0_if.rvalid), 32'd0);
      check({tag, ".r1_rvalid"},32'(r1_if.rvalid), 32'd0);
      check({tag, ".err_sel"},  32'(err_sel),      32'd0);
   endtask

   initial begin
      logic [1:0] exp_g;
      n_tests = 0;
      n_fail  = 0;
      rd_val  = 20'h0;
      reset   = 1'b0;
      drive1(1'b0, 1'b0, 3'd0, 12'h0, 20'h0);
      drive0(1'b1, 1'b1, 3'd1, 12'h041, 20'h0A89E);

      // Reset held with r0 requesting: nothing reaches memory
      for (int i = 0; i < 3; i++) begin
         tick();
         check_idle_outputs("rst");
      end

      // Release: r0 granted immediately, write issued next cycle
      reset = 1'b1;
      #1;
      check("wr.r0_gnt", 32'(r0_if.gnt), 32'd1);
      check("wr.r1_gnt", 32'(r1_if.gnt), 32'd0);
      tick();
      drive0(1'b0, 1'b0, 3'd0, 12'h0, 20'h0);
      check("wr.cwr",      32'(cwr),      32'd1);
      check("wr.crd",      32'(crd),      32'd0);
      check("wr.csel",     32'(csel),     32'd1);
      check("wr.caddr_wr", 32'(caddr_wr), 32'h041);
      check("wr.cdata_wr", 32'(cdata_wr), 32'h0A89E);
      tick();
      check("wr.cwr_off",  32'(cwr),      32'd0);

      // Read by r1: rvalid two cycles after gnt
      rd_val = 20'h01310;
      drive1(1'b1, 1'b0, 3'd1, 12'h7FF, 20'h0);
      #1;
      check("rd.r1_gnt", 32'(r1_if.gnt), 32'd1);
      check("rd.r0_gnt", 32'(r0_if.gnt), 32'd0);
      tick();
      drive1(1'b0, 1'b0, 3'd0, 12'h0, 20'h0);
      check("rd.crd",       32'(crd),          32'd1);
      check("rd.cwr",       32'(cwr),          32'd0);
      check("rd.caddr_rd",  32'(caddr_rd),     32'h7FF);
      check("rd.r1_rv_t1",  32'(r1_if.rvalid), 32'd0);
      check("rd.busy_t1",   32'(busy),         32'd1);
      tick();
      check("rd.r1_rvalid", 32'(r1_if.rvalid), 32'd1);
      check("rd.r1_rdata",  32'(r1_if.rdata),  32'h01310);
      check("rd.r0_rvalid", 32'(r0_if.rvalid), 32'd0);
      tick();
      check("rd.r1_rv_off", 32'(r1_if.rvalid), 32'd0);
      check("rd.r1_hold",   32'(r1_if.rdata),  32'h01310);
      check("rd.busy_idle", 32'(busy),         32'd0);

      // Move ownership back to r0, then one idle cycle clears the count
      drive0(1'b1, 1'b1, 3'd1, 12'h001, 20'h00001);
      tick();
      drive0(1'b0, 1'b1, 3'd1, 12'h001, 20'h00001);
      tick();

      // Contended burst: r0 x4, r1 x4, r0 x4
      drive0(1'b1, 1'b1, 3'd1, 12'h010, 20'h00010);
      drive1(1'b1, 1'b1, 3'd3, 12'h020, 20'h00020);
      for (int i = 0; i < 12; i++) begin
         #1;
         exp_g = (i < 4 || i >= 8) ? 2'b01 : 2'b10;
         check($sformatf("burst[%0d]", i), 32'({r1_if.gnt, r0_if.gnt}), 32'(exp_g));
         tick();
      end
      // Idle cycle restarts r0's budget: r0 x4 then r1
      drive0(1'b0, 1'b1, 3'd1, 12'h010, 20'h00010);
      drive1(1'b0, 1'b1, 3'd3, 12'h020, 20'h00020);
      tick();
      drive0(1'b1, 1'b1, 3'd1, 12'h010, 20'h00010);
      drive1(1'b1, 1'b1, 3'd3, 12'h020, 20'h00020);
      for (int i = 0; i < 5; i++) begin
         #1;
         exp_g = (i < 4) ? 2'b01 : 2'b10;
         check($sformatf("idle_burst[%0d]", i), 32'({r1_if.gnt, r0_if.gnt}), 32'(exp_g));
         tick();
      end
      drive0(1'b0, 1'b0, 3'd0, 12'h0, 20'h0);
      drive1(1'b0, 1'b0, 3'd0, 12'h0, 20'h0);
      tick();
      tick();

      // Reserved sel on a write: granted, no strobe, one-cycle err pulse
      drive0(1'b1, 1'b1, 3'd2, 12'h055, 20'h00055);
      #1;
      check("rsv_wr.gnt", 32'(r0_if.gnt), 32'd1);
      tick();
      drive0(1'b0, 1'b0, 3'd0, 12'h0, 20'h0);
      check("rsv_wr.cwr", 32'(cwr),     32'd0);
      check("rsv_wr.crd", 32'(crd),     32'd0);
      check("rsv_wr.err", 32'(err_sel), 32'd1);
      tick();
      check("rsv_wr.err_off", 32'(err_sel), 32'd0);

      // Reserved sel on a read: rvalid at +2 carrying zero
      rd_val = 20'hABCDE;
      drive0(1'b1, 1'b0, 3'd5, 12'h066, 20'h0);
      #1;
      check("rsv_rd.gnt", 32'(r0_if.gnt), 32'd1);
      tick();
      drive0(1'b0, 1'b0, 3'd0, 12'h0, 20'h0);
      check("rsv_rd.crd", 32'(crd),     32'd0);
      check("rsv_rd.err", 32'(err_sel), 32'd1);
      tick();
      check("rsv_rd.rvalid", 32'(r0_if.rvalid), 32'd1);
      check("rsv_rd.rdata",  32'(r0_if.rdata),  32'd0);
      tick();

      // Reset one cycle after a read grant: the read is lost
      rd_val = 20'h05A5A;
      drive1(1'b1, 1'b0, 3'd1, 12'h123, 20'h0);
      #1;
      check("rstrd.gnt", 32'(r1_if.gnt), 32'd1);
      tick();
      drive1(1'b0, 1'b0, 3'd0, 12'h0, 20'h0);
      reset = 1'b0;
      #1;
      check("rstrd.crd_in_rst", 32'(crd), 32'd0);
      tick();
      check("rstrd.rv_in_rst", 32'(r1_if.rvalid), 32'd0);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("rstrd.rv_after[%0d]", i), 32'(r1_if.rvalid), 32'd0);
         check($sformatf("rstrd.busy[%0d]", i),     32'(busy),         32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/layer_mem_arbiter.md
Name: layer_mem_arbiter

Overview:
- Shares the single layer-memory port (cwr/crd/csel/caddr_wr/caddr_rd/cdata_wr/cdata_rd) between two requesters:
  - r0: convolution engine, writes L0.
  - r1: pooling engine, reads L0 and writes L1.
- Lets conv and pooling run overlapped instead of strictly sequentially.
- Grants are round-robin, with a bounded burst length per owner.
- Memory commands are registered; read data is returned with a fixed latency.

Parameters:
- MAX_BURST, 4: max consecutive grants to one requester while the other is requesting (1..15).
- AW, 12: address width.
- DW, 20: data width.

Ports:
- clk, input, 1: clock; all logic on rising edge.
- reset, input, 1: asynchronous, active-low reset.
- r0_req, input, 1: requester 0 wants an access this cycle.
- r0_we, input, 1: 1 = write, 0 = read.
- r0_sel, input, 3: target memory select (1 = L0, 3 = L1, others reserved).
- r0_addr, input, AW: access address.
- r0_wdata, input, DW: write data.
- r0_gnt, output, 1: combinational grant; the access is accepted this cycle.
- r0_rvalid, output, 1: read data valid pulse.
- r0_rdata, output, DW: read data.
- r1_*: same set as r0_*, for requester 1.
- cwr, output, 1: memory write strobe.
- crd, output, 1: memory read strobe.
- csel, output, 3: memory select.
- caddr_wr, output, AW: write address.
- caddr_rd, output, AW: read address.
- cdata_wr, output, DW: write data.
- cdata_rd, input, DW: read data; valid in the cycle crd is high.
- busy, output, 1: any request pending or any read in flight.
- err_sel, output, 1: one-cycle pulse when a granted access carries a reserved sel.

Behaviour:
- State registers:
  - owner (1 bit)
  - cnt (4 bits, consecutive grants to owner)
  - the registered memory command
  - read-return pipeline: valid bit plus requester id
- Reset (reset low, asynchronous) clears:
  - owner = 0, cnt = 0.
  - cwr = crd = 0; csel = 0; caddr_wr = caddr_rd = 0; cdata_wr = 0.
  - r0/r1_rvalid = 0, rdata = 0; err_sel = 0.
  - Any in-flight read is discarded, with no rvalid after reset release.
- Grant decision (combinational, cycle t). At most one gnt is high.
  - Only one req high: that requester is granted.
  - Both high, cnt < MAX_BURST: owner is granted.
  - Both high, cnt >= MAX_BURST: the non-owner is granted.
  - Neither high: no grant.
- Update at the end of cycle t:
  - Granted requester == owner: cnt = min(cnt+1, 15).
  - Granted requester != owner: owner = granted requester, cnt = 1.
  - No grant: cnt = 0, owner unchanged.
- Command issue (registered; visible in cycle t+1):
  - Granted write: cwr = 1, crd = 0, caddr_wr = addr, cdata_wr = wdata, csel = sel.
  - Granted read: crd = 1, cwr = 0, caddr_rd = addr, csel = sel.
  - No grant: cwr = crd = 0; addresses, data and csel hold their previous values.
  - Reserved sel (0, 2, 4–7): grant is still given and the requester advances. In t+1, cwr = crd = 0 and err_sel = 1. A read with reserved sel returns rvalid at t+2 with rdata = 0.
- Read return: cdata_rd is sampled at the end of t+1. The originating requester sees rvalid = 1 for exactly one cycle at t+2, with rdata = the sampled value. The other requester's rvalid stays 0. rdata holds between pulses.
- Throughput and latency:
  - One access per cycle; back-to-back grants are allowed; reads and writes may interleave.
  - Up to two reads in flight (t+1 and t+2 stages).
  - Read latency is fixed at 2 cycles from gnt to rvalid.
- A requester keeps req and its fields stable until gnt; fields are sampled only in the gnt cycle.
- busy = r0_req | r1_req | (read in flight at stage t+1 or t+2).
- Same-address write followed by a read in the next cycle: the memory sees the write first (in order). No forwarding is done inside the arbiter.

Test Plan:
- Reset: hold reset low 3 cycles with r0_req = 1 → all outputs 0, no gnt issued to memory (cwr = crd = 0). Release → first gnt goes to r0 on the first cycle it requests.
- Single write: r0 writes sel = 1, addr = 0x041, wdata = 0x0A89E → next cycle cwr = 1, csel = 1, caddr_wr = 0x041, cdata_wr = 0x0A89E; crd = 0.
- Read latency: r1 reads sel = 1, addr = 0x7FF; memory drives cdata_rd = 0x01310 when crd = 1 → r1_rvalid = 1 exactly 2 cycles after r1_gnt, r1_rdata = 0x01310, r0_rvalid stays 0.
- Burst fairness: both req held high for 12 cycles, MAX_BURST = 4 → grant sequence r0×4, r1×4, r0×4. An idle cycle mid-burst resets cnt to 0.
- Reserved sel: r0 write with sel = 2 → gnt given, next cycle cwr = 0, err_sel = 1 for 1 cycle. A read with sel = 5 → rvalid at +2 with rdata = 0.
- Reset mid-read: assert reset one cycle after r1 read gnt → no r1_rvalid after release; busy = 0.
